mux_scheduler: RTL and testbench
================================

# mux_scheduler

Upstream sequencer for the three-input chip-select mux stage. Accepts bytes from three independent producers (alpha, beta, gamma) over valid/ready handshakes, holds each in a one-entry buffer, and time-multiplexes them onto the mux by driving `sel`/`cs` with round-robin fairness. Each grant holds `cs` for a programmable number of non-stalled cycles, so the downstream consumer of the mux output sees one source at a time.

## Interface
- `HOLD_CYCLES`, default 1: non-stalled cycles `cs` stays asserted per grant. Legal range is 1 to 255.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `a_valid` in 1; `a_data` in 8; `a_ready` out 1: alpha producer handshake.
- `b_valid` in 1; `b_data` in 8; `b_ready` out 1: beta producer handshake.
- `g_valid` in 1; `g_data` in 8; `g_ready` out 1: gamma producer handshake.
- `stall` in 1: downstream not consuming. It freezes the grant countdown.
- `sel` out 2: mux select. 0 = alpha, 1 = beta, 2 = gamma, 3 = none.
- `cs` out 1: mux chip select. High only during a grant.
- `alpha`, `beta`, `gamma` out 8 each: buffered source bytes, wired to the mux data inputs.

## Operation
- **Buffers.** Each channel has an 8-bit register and a `full` flag.
  - `x_ready = !full_x && !reset`.
  - Capture occurs on `valid && ready` at an edge: the register loads the data and `full` is set.
  - The data output equals the register at all times.
  - The register is never written while `full` is set.
- **FSM states.**
  - IDLE: `cs=0`, `sel=3`.
  - GRANT: `cs=1`, `sel` = granted channel. Holds a counter `cnt`, width `$clog2(HOLD_CYCLES+1)`.
- **IDLE → GRANT.** Taken at an edge where any `full` flag is set.
  - The channel is chosen by round-robin starting after `last`, the last granted channel, in order alpha → beta → gamma → alpha.
  - After reset, `last` = gamma, so alpha has first priority.
  - Load `cnt = HOLD_CYCLES`.
- **In GRANT, with `stall=1`.** `cnt`, `sel` and `cs` all hold.
- **In GRANT, with `stall=0` and `cnt>1`.** Decrement `cnt`.
- **In GRANT, with `stall=0` and `cnt==1` (completion).**
  - Clear `full` of the granted channel and set `last` to it.
  - If any other channel is full, go directly to GRANT for the next round-robin channel, excluding the one just completed, and reload `cnt`. `cs` stays high; `sel` changes.
  - Otherwise go to IDLE.
- **Fairness.** The granted channel's own buffer cannot refill during its grant because ready is low. A continuously-valid producer therefore cannot starve the others.
- **Reset.** Reset always wins, including mid-grant. On the reset edge:
  - all `full` = 0, all data registers = 0, `last` = gamma, FSM = IDLE, `cnt` = 0;
  - outputs: `cs=0`, `sel=3`, `alpha`/`beta`/`gamma` = 0.
  - All ready outputs are low while `reset` is high and high from the first cycle after reset deasserts.
  - A byte mid-grant is dropped.

## Timing
- **Capture to grant.** A byte captured at edge E0 (`full=1` after E0) is granted at edge E1 at the earliest: `cs=1` and `sel` valid in the cycle after E1.
  - This holds only if the FSM was in IDLE, or completes a grant at E1 with this channel next in round-robin order.
- **Grant length.** A grant lasts exactly `HOLD_CYCLES` cycles plus the number of cycles `stall` is high during it.
- **Refill after completion.** After completion at edge Ec, the channel's ready goes high in the cycle after Ec. The earliest recapture is edge Ec+1, which gives a one-cycle bubble per channel.
- **Back-to-back grants.** With 3 full channels and `stall=0`, `cs` is continuously high and `sel` steps every `HOLD_CYCLES` cycles.
- **Simultaneous events.**
  - Captures on several channels at the same edge are all accepted.
  - A capture on a non-granted channel at a completion edge is not visible to the arbitration at that edge. It is arbitrated at the next edge.
- **Outputs.** `sel`, `cs` and the data outputs are registered. No combinational path runs from inputs to them.
- **Ready outputs.** Each ready is combinational only from its own `full` flag and `reset`.

## Test plan
- **Reset state.** Assert reset for 2 cycles with all valids high → ready = 0 throughout. After deassert: `cs=0`, `sel=3`, `alpha`/`beta`/`gamma` = 0x00, ready = 1.
- **Single byte.** `HOLD_CYCLES=1`, `a_data=0x5A` captured at E0 → `cs=1`, `sel=0`, `alpha=0x5A` in the cycle after E1. `cs=0`, `sel=3` after E2. `a_ready` = 1 after E2.
- **Round-robin.** All three buffers full simultaneously (`0x11`, `0x22`, `0x33`), `HOLD_CYCLES=2` → `sel` sequence 0,0,1,1,2,2 with `cs` high for 6 consecutive cycles, then IDLE. Next, refill only alpha and gamma → the grant order is alpha, then gamma.
- **Stall.** `HOLD_CYCLES=3`, beta granted, `stall` high for 4 cycles mid-grant → `cs` high for 7 cycles, `sel=1` throughout, and `beta` stable.
- **Fairness.** Alpha valid held continuously, beta captured once → beta is granted immediately after the current alpha grant completes, never after two alpha grants.
- **Reset mid-grant.** Reset asserted during a gamma grant → the next cycle shows `cs=0`, `sel=3`, `gamma=0x00`, and no grant follows once reset deasserts, because the buffers are empty.

Source files
------------

// File: rtl/mux_scheduler.sv
// Three-source sequencer for the chip-select mux: buffers one byte per producer
// and grants the mux round-robin, holding cs for HOLD_CYCLES non-stalled cycles.
module mux_scheduler #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  input  logic       g_valid,
  input  logic [7:0] g_data,
  output logic       g_ready,
  input  logic       stall,
  output logic [1:0] sel,
  output logic       cs,
  output logic [7:0] alpha,
  output logic [7:0] beta,
  output logic [7:0] gamma
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam logic [1:0] CH_A    = 2'd0;
  localparam logic [1:0] CH_G    = 2'd2;
  localparam logic [1:0] CH_NONE = 2'd3;

  logic             state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic [1:0]       last;
  logic [2:0]       full;
  logic [2:0]       full_next;
  logic [7:0]       reg_a, reg_b, reg_g;
  logic [1:0]       idle_pick;
  logic [1:0]       done_pick;
  logic             complete;

  assign a_ready = !full[0] && !reset;
  assign b_ready = !full[1] && !reset;
  assign g_ready = !full[2] && !reset;

  assign alpha = reg_a;
  assign beta  = reg_b;
  assign gamma = reg_g;

  // First requesting channel after prev in alpha -> beta -> gamma order.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] prev);
    logic [1:0] result;
    logic [1:0] ch;
    result = CH_NONE;
    for (int i = 3; i >= 1; i--) begin
      ch = 2'((int'(prev) + i) % 3);
      if (req[ch]) result = ch;
    end
    return result;
  endfunction

  assign complete  = (state == ST_GRANT) && !stall && (cnt == CNT_ONE);
  assign idle_pick = rr_pick(full, last);
  // The channel being completed is masked so the next grant always moves on.
  assign done_pick = rr_pick(full & ~(3'b001 << grant), grant);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    full_next = full;
    if (complete) full_next[grant] = 1'b0;
    if (a_valid && a_ready) full_next[0] = 1'b1;
    if (b_valid && b_ready) full_next[1] = 1'b1;
    if (g_valid && g_ready) full_next[2] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      grant <= CH_A;
      last  <= CH_G;
      full  <= '0;
      reg_a <= '0;
      reg_b <= '0;
      reg_g <= '0;
      sel   <= CH_NONE;
      cs    <= 1'b0;
    end else begin
      full <= full_next;
      if (a_valid && a_ready) reg_a <= a_data;
      if (b_valid && b_ready) reg_b <= b_data;
      if (g_valid && g_ready) reg_g <= g_data;

      case (state)
        ST_IDLE: begin
          if (idle_pick != CH_NONE) begin
            state <= ST_GRANT;
            grant <= idle_pick;
            sel   <= idle_pick;
            cs    <= 1'b1;
            cnt   <= CNT_LOAD;
          end
        end
        default: begin
          if (!stall) begin
            if (cnt != CNT_ONE) begin
              cnt <= cnt - CNT_ONE;
            end else begin
              last <= grant;
              if (done_pick != CH_NONE) begin
                grant <= done_pick;
                sel   <= done_pick;
                cnt   <= CNT_LOAD;
              end else begin
                state <= ST_IDLE;
                sel   <= CH_NONE;
                cs    <= 1'b0;
                cnt   <= '0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scheduler.sv
// Directed bench for mux_scheduler: three instances (HOLD_CYCLES = 1, 2, 3)
// share stimulus; each scenario checks the instance whose hold length it needs.
module tb_mux_scheduler;

  logic       clk;
  logic       reset;
  logic       a_valid, b_valid, g_valid;
  logic [7:0] a_data, b_data, g_data;
  logic       stall;

  logic       a_ready [3];
  logic       b_ready [3];
  logic       g_ready [3];
  logic [1:0] sel     [3];
  logic       cs      [3];
  logic [7:0] alpha   [3];
  logic [7:0] beta    [3];
  logic [7:0] gamma   [3];

  int checks;
  int failures;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    mux_scheduler #(.HOLD_CYCLES(i + 1)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_valid (a_valid),
      .a_data  (a_data),
      .a_ready (a_ready[i]),
      .b_valid (b_valid),
      .b_data  (b_data),
      .b_ready (b_ready[i]),
      .g_valid (g_valid),
      .g_data  (g_data),
      .g_ready (g_ready[i]),
      .stall   (stall),
      .sel     (sel[i]),
      .cs      (cs[i]),
      .alpha   (alpha[i]),
      .beta    (beta[i]),
      .gamma   (gamma[i])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic grant_is(input int d, input string tag, input logic [1:0] exp_sel, input logic exp_cs);
    check({tag, "_sel"}, 32'(sel[d]), 32'(exp_sel));
    check({tag, "_cs"},  32'(cs[d]),  32'(exp_cs));
  endtask

  logic [1:0] rr_seq [6];
  logic [1:0] ag_seq [4];

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    a_valid  = 1'b1; a_data = 8'hE1;
    b_valid  = 1'b1; b_data = 8'hE2;
    g_valid  = 1'b1; g_data = 8'hE3;

    // Reset held two cycles with every valid high: nothing may be accepted.
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_a_ready", 32'(a_ready[0]), 32'd0);
      check("rst_b_ready", 32'(b_ready[0]), 32'd0);
      check("rst_g_ready", 32'(g_ready[0]), 32'd0);
    end
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; g_valid = 1'b0;
    #1;
    grant_is(0, "rst", 2'd3, 1'b0);
    check("rst_alpha", 32'(alpha[0]), 32'h00);
    check("rst_beta",  32'(beta[0]),  32'h00);
    check("rst_gamma", 32'(gamma[0]), 32'h00);
    check("rst_a_ready_after", 32'(a_ready[0]), 32'd1);
    check("rst_g_ready_after", 32'(g_ready[0]), 32'd1);

    // Single byte, HOLD_CYCLES=1.
    a_valid = 1'b1; a_data = 8'h5A;
    tick();                                   // E0: capture
    a_valid = 1'b0;
    grant_is(0, "single_e0", 2'd3, 1'b0);
    check("single_e0_a_ready", 32'(a_ready[0]), 32'd0);
    tick();                                   // E1: grant
    grant_is(0, "single_e1", 2'd0, 1'b1);
    check("single_e1_alpha", 32'(alpha[0]), 32'h5A);
    tick();                                   // E2: complete
    grant_is(0, "single_e2", 2'd3, 1'b0);
    check("single_e2_a_ready", 32'(a_ready[0]), 32'd1);

    // Round-robin, HOLD_CYCLES=2: all three full at once.
    do_reset();
    a_valid = 1'b1; a_data = 8'h11;
    b_valid = 1'b1; b_data = 8'h22;
    g_valid = 1'b1; g_data = 8'h33;
    tick();
    a_valid = 1'b0; b_valid = 1'b0; g_valid = 1'b0;
    check("rr_beta", 32'(beta[1]), 32'h22);
    rr_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    for (int c = 0; c < 6; c++) begin
      tick();
      grant_is(1, $sformatf("rr_c%0d", c), rr_seq[c], 1'b1);
    end
    tick();
    grant_is(1, "rr_idle", 2'd3, 1'b0);
    // Refill alpha and gamma only: alpha first, then gamma.
    a_valid = 1'b1; a_data = 8'h44;
    g_valid = 1'b1; g_data = 8'h55;
    tick();
    a_valid = 1'b0; g_valid = 1'b0;
    ag_seq = '{2'd0, 2'd0, 2'd2, 2'd2};
    for (int c = 0; c < 4; c++) begin
      tick();
      grant_is(1, $sformatf("ag_c%0d", c), ag_seq[c], 1'b1);
    end
    check("ag_alpha", 32'(alpha[1]), 32'h44);
    check("ag_gamma", 32'(gamma[1]), 32'h55);
    tick();
    grant_is(1, "ag_idle", 2'd3, 1'b0);

    // Stall, HOLD_CYCLES=3: beta grant stretched by 4 stalled cycles to 7.
    do_reset();
    b_valid = 1'b1; b_data = 8'h77;
    tick();
    b_valid = 1'b0;
    tick();
    grant_is(2, "stall_c0", 2'd1, 1'b1);
    stall = 1'b1;
    for (int c = 1; c < 7; c++) begin
      if (c == 5) stall = 1'b0;
      tick();
      grant_is(2, $sformatf("stall_c%0d", c), 2'd1, 1'b1);
      check($sformatf("stall_beta_c%0d", c), 32'(beta[2]), 32'h77);
    end
    tick();
    grant_is(2, "stall_end", 2'd3, 1'b0);

    // Fairness, HOLD_CYCLES=2: alpha valid held, beta captured once.
    do_reset();
    a_valid = 1'b1; a_data = 8'hA1;
    tick();                                   // E0: alpha captured
    b_valid = 1'b1; b_data = 8'hB1;
    tick();                                   // E1: alpha granted, beta captured
    b_valid = 1'b0; a_data = 8'hA2;
    grant_is(1, "fair_e1", 2'd0, 1'b1);
    tick();
    grant_is(1, "fair_e2", 2'd0, 1'b1);
    tick();                                   // E3: alpha completes, beta next
    grant_is(1, "fair_e3", 2'd1, 1'b1);
    check("fair_e3_a_ready", 32'(a_ready[1]), 32'd1);
    check("fair_e3_beta", 32'(beta[1]), 32'hB1);
    tick();                                   // E4: alpha recaptured
    grant_is(1, "fair_e4", 2'd1, 1'b1);
    tick();
    grant_is(1, "fair_e5", 2'd0, 1'b1);
    check("fair_e5_alpha", 32'(alpha[1]), 32'hA2);
    a_valid = 1'b0;

    // Reset mid-grant, HOLD_CYCLES=3: gamma byte dropped, no later grant.
    do_reset();
    g_valid = 1'b1; g_data = 8'hC3;
    tick();
    g_valid = 1'b0;
    tick();
    grant_is(2, "midrst_grant", 2'd2, 1'b1);
    check("midrst_gamma_pre", 32'(gamma[2]), 32'hC3);
    reset = 1'b1;
    tick();
    grant_is(2, "midrst_reset", 2'd3, 1'b0);
    check("midrst_gamma", 32'(gamma[2]), 32'h00);
    check("midrst_g_ready", 32'(g_ready[2]), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      grant_is(2, $sformatf("midrst_after_c%0d", c), 2'd3, 1'b0);
    end
    check("midrst_g_ready_after", 32'(g_ready[2]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
